mem_a_skew: RTL and testbench

- Operand-A buffer for the DIM x DIM systolic matrix-multiply array.
- Holds DIM rows of DIM signed BITS_AB-bit elements; each row is loaded in parallel.
- Streams the rows out one element per enabled cycle, with row r delayed by r cycles to produce the diagonal skew the array needs.

---
 rtl/mem_a_skew_pkg.sv | 11 +
 rtl/mem_a_skew_if.sv | 24 ++
 rtl/mem_a_skew_a_row_fifo.sv | 64 ++++++
 rtl/mem_a_skew.sv | 42 ++++
 tb/tb_mem_a_skew.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_a_skew_pkg.sv
// Shared definitions for the operand-A skew buffer of the systolic array.
// Holds the default parameters and the signed element type.
package mem_a_skew_pkg;

  localparam int BITS_AB_DEF = 8;   // width of a signed A element
  localparam int BITS_C_DEF  = 16;  // accumulator width of the array
  localparam int DIM_DEF     = 8;   // array dimension

  typedef logic signed [BITS_AB_DEF-1:0] a_elem_t;

endpackage

// File: rtl/mem_a_skew_if.sv
// Load/stream bus of the operand-A skew buffer.
//   en   : shift enable for every row and skew stage
//   WrEn : parallel-load strobe for row Arow
//   Ain  : row data, Ain[0] leaves first
//   Arow : row index to load
//   Aout : per-row skewed output element
// master drives the load/enable side, slave is the buffer.
interface mem_a_skew_if
  import mem_a_skew_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
);

  logic                      en;
  logic                      WrEn;
  logic signed [BITS_AB-1:0] Ain  [DIM];
  logic [$clog2(DIM)-1:0]    Arow;
  logic signed [BITS_AB-1:0] Aout [DIM];

  modport master (output en, WrEn, Ain, Arow, input Aout);
  modport slave  (input en, WrEn, Ain, Arow, output Aout);

endinterface

// File: rtl/mem_a_skew_a_row_fifo.sv
// One row of the operand-A buffer: a DEPTH-entry parallel-load shift
// register whose head feeds a SKEW-stage delay chain.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH (name kept from the codebase)
//   en    : shift enable for main register and skew chain
//   wr    : parallel load of din into the main register (wins over shift)
//   din   : row data, din[0] becomes the head
//   dout  : head (SKEW=0) or last skew stage
module a_row_fifo
  import mem_a_skew_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DEPTH   = DIM_DEF,
  parameter int SKEW    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr,
  input  logic signed [BITS_AB-1:0] din [DEPTH],
  output logic signed [BITS_AB-1:0] dout
);

  logic signed [BITS_AB-1:0] m_q [DEPTH];
  logic signed [BITS_AB-1:0] m_d [DEPTH];

  always_comb begin
    for (int unsigned j = 0; j < DEPTH; j++) m_d[j] = m_q[j];
    if (wr) begin
      for (int unsigned j = 0; j < DEPTH; j++) m_d[j] = din[j];
    end else if (en) begin
      for (int unsigned j = 0; j < DEPTH - 1; j++) m_d[j] = m_q[j+1];
      m_d[DEPTH-1] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) m_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) m_q[j] <= m_d[j];
    end
  end

  if (SKEW == 0) begin : g_noskew
    assign dout = m_q[0];
  end else begin : g_skew
    // The chain samples the old head even on a load cycle, so data already
    // leaving the row keeps draining after a mid-stream reload.
    logic signed [BITS_AB-1:0] s_q [SKEW];

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        for (int unsigned j = 0; j < SKEW; j++) s_q[j] <= '0;
      end else if (en) begin
        s_q[0] <= m_q[0];
        for (int unsigned j = 1; j < SKEW; j++) s_q[j] <= s_q[j-1];
      end
    end

    assign dout = s_q[SKEW-1];
  end

endmodule

// File: rtl/mem_a_skew.sv
// Operand-A buffer for a DIM x DIM systolic matrix multiply. Each of DIM
// rows is parallel-loaded and streamed out one element per enabled cycle,
// row r delayed by r cycles to form the diagonal skew.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH
//   a     : load/stream bus (slave side), see mem_a_skew_if
// BITS_C is carried only to keep parameter lists uniform across the array.
module mem_a_skew
  import mem_a_skew_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int BITS_C  = BITS_C_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_a_skew_if.slave  a
);

  localparam int AW = $clog2(DIM);

  for (genvar r = 0; r < DIM; r++) begin : g_row
    localparam logic [AW-1:0] ROW = AW'(r);
    logic wr;

    assign wr = a.WrEn && (a.Arow == ROW);

    a_row_fifo #(
      .BITS_AB (BITS_AB),
      .DEPTH   (DIM),
      .SKEW    (r)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (a.en),
      .wr    (wr),
      .din   (a.Ain),
      .dout  (a.Aout[r])
    );
  end

endmodule

// File: tb/tb_mem_a_skew.sv
// Self-checking bench for mem_a_skew: table-driven load/stream vectors,
// hand-written corner sequences and a randomized run checked against a
// reference model that records each row's head value per enabled cycle.
module tb_mem_a_skew;
  import mem_a_skew_pkg::*;

  localparam int DIM  = 8;
  localparam int BITS = 8;
  localparam int AW   = $clog2(DIM);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_a_skew_if #(.BITS_AB(BITS), .DIM(DIM)) bus ();

  mem_a_skew #(.BITS_AB(BITS), .BITS_C(16), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current contents of each row, and for every row the
  // head value seen at each enabled edge since reset.
  int mm   [DIM][DIM];
  int hist [DIM][$];

  typedef struct {
    bit en;
    bit wr;
    int row;
    int base;
    int exp [DIM];
  } vec_t;
  vec_t tbl [$];

  function automatic int model_out(int r);
    if (r == 0) return mm[0][0];
    if (hist[r].size() >= r) return hist[r][hist[r].size() - r];
    return 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < DIM; r++) begin
      hist[r].delete();
      for (int j = 0; j < DIM; j++) mm[r][j] = 0;
    end
  endtask

  task automatic model_edge(input bit en, input bit wr, input int row,
                            input int ain [DIM]);
    for (int r = 0; r < DIM; r++) begin
      if (en) hist[r].push_back(mm[r][0]);
      if (wr && row == r) begin
        for (int j = 0; j < DIM; j++) mm[r][j] = ain[j];
      end else if (en) begin
        for (int j = 0; j < DIM - 1; j++) mm[r][j] = mm[r][j+1];
        mm[r][DIM-1] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int r = 0; r < DIM; r++)
      chk($sformatf("%s Aout[%0d]", tag, r), int'(bus.Aout[r]), model_out(r));
  endtask

  // Drive one clock cycle's inputs, advance the model and sample #1 later.
  task automatic cyc(input bit en, input bit wr, input int row,
                     input int ain [DIM]);
    bus.en   = en;
    bus.WrEn = wr;
    bus.Arow = row[AW-1:0];
    for (int j = 0; j < DIM; j++) bus.Ain[j] = BITS'(ain[j]);
    @(posedge clk);
    model_edge(en, wr, row, ain);
    #1;
  endtask

  task automatic idle(input bit en);
    int z [DIM];
    for (int j = 0; j < DIM; j++) z[j] = 0;
    cyc(en, 1'b0, 0, z);
  endtask

  // Asynchronous reset with random inputs; outputs must clear with no edge.
  task automatic do_reset(input string tag);
    bus.en   = 1'($urandom);
    bus.WrEn = 1'($urandom);
    bus.Arow = AW'($urandom);
    for (int j = 0; j < DIM; j++) bus.Ain[j] = BITS'($urandom);
    rst_n = 1'b1;
    #1;
    model_clear();
    for (int r = 0; r < DIM; r++)
      chk($sformatf("%s reset Aout[%0d]", tag, r), int'(bus.Aout[r]), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    int ain [DIM];

    bus.en = 1'b0; bus.WrEn = 1'b0; bus.Arow = '0;
    for (int j = 0; j < DIM; j++) bus.Ain[j] = '0;
    #1;
    do_reset("init");

    // ---- table: load all rows idle, hold, then stream k=1..14 ----
    for (int i = 0; i < DIM; i++) begin
      vec_t v;
      v.en = 1'b0; v.wr = 1'b1; v.row = i; v.base = i + 1;
      for (int r = 0; r < DIM; r++) v.exp[r] = (r == 0) ? 1 : 0;
      tbl.push_back(v);
    end
    for (int i = 0; i < 2; i++) begin
      vec_t v;
      v.en = 1'b0; v.wr = 1'b0; v.row = 0; v.base = 0;
      for (int r = 0; r < DIM; r++) v.exp[r] = (r == 0) ? 1 : 0;
      tbl.push_back(v);
    end
    for (int k = 1; k <= 2 * DIM - 2; k++) begin
      vec_t v;
      v.en = 1'b1; v.wr = 1'b0; v.row = 0; v.base = 0;
      for (int r = 0; r < DIM; r++)
        v.exp[r] = (k - r >= 0 && k - r <= DIM - 1) ? k + 1 : 0;
      tbl.push_back(v);
    end
    foreach (tbl[n]) begin
      for (int j = 0; j < DIM; j++) ain[j] = tbl[n].base + j;
      cyc(tbl[n].en, tbl[n].wr, tbl[n].row, ain);
      for (int r = 0; r < DIM; r++)
        chk($sformatf("tbl%0d Aout[%0d]", n, r), int'(bus.Aout[r]), tbl[n].exp[r]);
    end

    // ---- load while streaming ----
    do_reset("ldEn");
    for (int j = 0; j < DIM; j++) ain[j] = j + 1;
    cyc(1'b1, 1'b1, 0, ain);
    chk("ldEn first Aout[0]", int'(bus.Aout[0]), 1);
    for (int j = 0; j < DIM; j++) ain[j] = j + 2;
    cyc(1'b1, 1'b1, 1, ain);
    chk("ldEn row0 shifted", int'(bus.Aout[0]), 2);
    chk("ldEn row1 skew old head", int'(bus.Aout[1]), 0);
    idle(1'b1);
    chk("ldEn row1 first", int'(bus.Aout[1]), 2);
    chk("ldEn row0 next", int'(bus.Aout[0]), 3);
    check_model("ldEn");

    // ---- signed passthrough on row 3 ----
    do_reset("sgn");
    for (int j = 0; j < DIM; j++) ain[j] = -128 + j;
    cyc(1'b0, 1'b1, 3, ain);
    for (int k = 1; k <= 12; k++) begin
      idle(1'b1);
      chk($sformatf("sgn k%0d Aout[3]", k), int'(bus.Aout[3]),
          (k >= 3 && k <= 10) ? -128 + (k - 3) : 0);
    end

    // ---- hold mid-stream, then resume; reset mid-stream ----
    do_reset("hold");
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) ain[j] = int'($urandom_range(0, 255)) - 128;
      cyc(1'b0, 1'b1, i, ain);
    end
    for (int k = 0; k < 4; k++) begin idle(1'b1); check_model("hold run"); end
    for (int k = 0; k < 5; k++) begin idle(1'b0); check_model("hold off"); end
    for (int k = 0; k < 6; k++) begin idle(1'b1); check_model("hold resume"); end
    do_reset("mid");
    idle(1'b1);
    check_model("mid after");

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      for (int j = 0; j < DIM; j++) ain[j] = int'($urandom_range(0, 255)) - 128;
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
          int'($urandom_range(0, DIM - 1)), ain);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
